// File: rtl/cordic_rot_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : cordic_rot_seq_if
//  Description : Bundle between the CORDIC rotation sequencer and its
//                requester / x-y stage environment.
//                master : requester + stages (drives start, angle, x_in, y_in)
//                slave  : sequencer (drives stage controls, operands, z, status)
//  Signals     : start, angle[15:0]         request and Q3.13 target angle
//                x_in[15:0], y_in[15:0]     current stage register values
//                stage_load, stage_stop     stage load / hold controls
//                x_cin, y_cin               stage add(0) / subtract(1) selects
//                x_opnd, y_opnd [15:0]      shifted cross-operands
//                z_out[15:0], iter_idx[3:0] residual angle, iteration index
//                busy, done                 status and completion pulse
//  Revision    : 1.0  initial release
// ============================================================================
interface cordic_rot_seq_if;
   logic        start;
   logic [15:0] angle;
   logic [15:0] x_in;
   logic [15:0] y_in;
   logic        stage_load;
   logic        stage_stop;
   logic        x_cin;
   logic        y_cin;
   logic [15:0] x_opnd;
   logic [15:0] y_opnd;
   logic [15:0] z_out;
   logic [3:0]  iter_idx;
   logic        busy;
   logic        done;

   modport master (
      output start, angle, x_in, y_in,
      input  stage_load, stage_stop, x_cin, y_cin, x_opnd, y_opnd,
             z_out, iter_idx, busy, done
   );

   modport slave (
      input  start, angle, x_in, y_in,
      output stage_load, stage_stop, x_cin, y_cin, x_opnd, y_opnd,
             z_out, iter_idx, busy, done
   );
endinterface
`default_nettype wire

// File: rtl/cordic_rot_seq.sv
`default_nettype none
// ============================================================================
//  Module      : cordic_rot_seq
//  Description : Iteration sequencer and angle datapath for a 16-bit
//                rotation-mode CORDIC. Loads the external x/y stages, then
//                for ITER cycles supplies shifted cross-operands and
//                add/subtract selects while driving the residual angle z
//                toward zero through an arctan ROM. Pulses done at the end.
//  Parameters  : ITER   number of micro-rotations, 1..16
//  Ports       : clk    clock, rising edge
//                reset  synchronous, active-high reset
//                bus    cordic_rot_seq_if.slave (request, stage controls,
//                       operands, residual angle, status)
//  Revision    : 1.0  initial release
// ============================================================================
module cordic_rot_seq #(
   parameter int ITER = 14
) (
   input  wire logic        clk,
   input  wire logic        reset,
   cordic_rot_seq_if.slave  bus
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_ITER = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   localparam logic [3:0] LAST_IDX = 4'(ITER - 1);

   logic [1:0]  state_q, state_d;
   logic [3:0]  iter_q,  iter_d;
   logic [15:0] z_q,     z_d;

   logic        in_iter;
   logic        sigma;
   logic [15:0] atan_val;

   // round(atan(2^-i) * 2^13); the last two entries have dropped below 1 LSB.
   function automatic logic [15:0] atan_lut(input logic [3:0] idx);
      logic [15:0] v;
      case (idx)
         4'd0:    v = 16'd6434;
         4'd1:    v = 16'd3798;
         4'd2:    v = 16'd2007;
         4'd3:    v = 16'd1019;
         4'd4:    v = 16'd511;
         4'd5:    v = 16'd256;
         4'd6:    v = 16'd128;
         4'd7:    v = 16'd64;
         4'd8:    v = 16'd32;
         4'd9:    v = 16'd16;
         4'd10:   v = 16'd8;
         4'd11:   v = 16'd4;
         4'd12:   v = 16'd2;
         4'd13:   v = 16'd1;
         default: v = 16'd0;
      endcase
      return v;
   endfunction

   assign in_iter  = (state_q == ST_ITER);
   // Rotate toward zero: non-negative residual means rotate clockwise in z.
   assign sigma    = ~z_q[15];
   assign atan_val = atan_lut(iter_q);

   always_comb begin
      state_d = state_q;
      iter_d  = iter_q;
      z_d     = z_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               state_d = ST_LOAD;
               z_d     = bus.angle;
               iter_d  = 4'd0;
            end
         end
         ST_LOAD: begin
            state_d = ST_ITER;
         end
         ST_ITER: begin
            iter_d = iter_q + 4'd1;
            z_d    = sigma ? (z_q - atan_val) : (z_q + atan_val);
            if (iter_q == LAST_IDX) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         iter_q  <= 4'd0;
         z_q     <= 16'd0;
      end else begin
         state_q <= state_d;
         iter_q  <= iter_d;
         z_q     <= z_d;
      end
   end

   // Control outputs are pure decodes of registered state/z, so there is no
   // combinational path from start or angle.
   assign bus.stage_load = (state_q == ST_LOAD);
   assign bus.stage_stop = ~in_iter;
   assign bus.busy       = (state_q != ST_IDLE);
   assign bus.done       = (state_q == ST_DONE);
   assign bus.x_cin      = in_iter &  sigma;
   assign bus.y_cin      = in_iter & ~sigma;
   assign bus.z_out      = z_q;
   assign bus.iter_idx   = iter_q;

   // Cross-operands; a shift of 15 leaves only sign bits.
   assign bus.x_opnd = $signed(bus.y_in) >>> iter_q;
   assign bus.y_opnd = $signed(bus.x_in) >>> iter_q;

endmodule
`default_nettype wire

// File: tb/tb_cordic_rot_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cordic_rot_seq
//  Description : Self-checking bench for cordic_rot_seq with behavioural
//                x/y stages, a vector table and directed corner sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cordic_rot_seq;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   cordic_rot_seq_if bus();

   cordic_rot_seq #(.ITER(14)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Behavioural register-plus-adder stages.
   logic [15:0] sx, sy, sx0, sy0;
   always @(posedge clk) begin
      if (bus.stage_load) begin
         sx <= sx0;
         sy <= sy0;
      end else if (!bus.stage_stop) begin
         sx <= bus.x_cin ? (sx - bus.x_opnd) : (sx + bus.x_opnd);
         sy <= bus.y_cin ? (sy - bus.y_opnd) : (sy + bus.y_opnd);
      end
   end
   assign bus.x_in = sx;
   assign bus.y_in = sy;

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)",
                  name, $signed(act), act, $signed(exp), exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pulse start for one cycle and wait (bounded) for done; lat counts
   // cycles after the sampling edge.
   task automatic run_op(input logic [15:0] ang, input logic [15:0] x0,
                         input logic [15:0] y0, output int lat);
      sx0       = x0;
      sy0       = y0;
      bus.angle = ang;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      lat = 1;
      while (!bus.done && lat < 60) begin
         tick();
         lat++;
      end
   endtask

   typedef struct {
      logic [15:0] angle;
      logic [15:0] x0;
      logic [15:0] y0;
      logic [15:0] ex;
      logic [15:0] ey;
      logic [15:0] ez;
      bit          chk_xy;
   } vec_t;

   vec_t vt[4];

   int          sig_exp[14];
   int          ztr[14];
   int          lat;
   int          loads;
   int          first_gap;
   int          last_load;
   logic        prev_load;
   logic        saw_done;

   initial begin
      vt[0] = '{16'd0,       16'd4975, 16'd0, 16'd0,    16'd0,        16'd0,    1'b0};
      vt[1] = '{16'd4289,    16'd4975, 16'd0, 16'd7098, 16'd4095,     16'hFFFF, 1'b1};
      vt[2] = '{16'(-4289),  16'd4975, 16'd0, 16'd7099, 16'(-4095),   16'hFFFF, 1'b1};
      vt[3] = '{16'(-6434),  16'd4975, 16'd0, 16'd0,    16'd0,        16'd0,    1'b0};

      sig_exp = '{1,0,0,0,1,0,1,1,0,0,0,0,1,1};
      ztr     = '{-6434,-2636,-629,390,-121,135,7,-57,-25,-9,-1,3,1,0};

      sx0 = 16'd0;
      sy0 = 16'd0;
      bus.angle = 16'd0;

      // Reset with start held: nothing may begin.
      reset     = 1'b1;
      bus.start = 1'b1;
      for (int k = 0; k < 2; k++) begin
         tick();
         chk("rst_stop", 16'(bus.stage_stop), 16'd1);
         chk("rst_load", 16'(bus.stage_load), 16'd0);
         chk("rst_busy", 16'(bus.busy),       16'd0);
         chk("rst_z",    bus.z_out,           16'd0);
         chk("rst_cin",  {14'd0, bus.x_cin, bus.y_cin}, 16'd0);
      end
      bus.start = 1'b0;
      reset     = 1'b0;
      tick();
      chk("post_rst_busy", 16'(bus.busy), 16'd0);

      // Table-driven operations.
      for (int v = 0; v < 4; v++) begin
         run_op(vt[v].angle, vt[v].x0, vt[v].y0, lat);
         chk("latency", 16'(lat), 16'd16);
         chk("z_final", bus.z_out, vt[v].ez);
         if (vt[v].chk_xy) begin
            chk("x_final", sx, vt[v].ex);
            chk("y_final", sy, vt[v].ey);
         end
         tick();
         chk("after_done_busy", 16'(bus.busy), 16'd0);
         chk("after_done_done", 16'(bus.done), 16'd0);
         if (vt[v].chk_xy) begin
            chk("x_hold", sx, vt[v].ex);
         end
      end

      // angle = 0: full sigma / z trace and operand shifts.
      sx0 = 16'd4975;
      sy0 = 16'd0;
      bus.angle = 16'd0;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      chk("seq_load",      16'(bus.stage_load), 16'd1);
      chk("seq_load_stop", 16'(bus.stage_stop), 16'd1);
      chk("seq_load_busy", 16'(bus.busy),       16'd1);
      for (int k = 0; k < 14; k++) begin
         tick();
         chk("seq_idx",  16'(bus.iter_idx), 16'(k));
         chk("seq_xcin", 16'(bus.x_cin), 16'(sig_exp[k]));
         chk("seq_ycin", 16'(bus.y_cin), 16'(1 - sig_exp[k]));
         chk("seq_stop", 16'(bus.stage_stop), 16'd0);
         chk("seq_z",    bus.z_out, (k == 0) ? 16'd0 : 16'(ztr[k-1]));
         chk("seq_xop",  bus.x_opnd, 16'($signed(sy) >>> k));
         chk("seq_yop",  bus.y_opnd, 16'($signed(sx) >>> k));
      end
      tick();
      chk("seq_done",      16'(bus.done), 16'd1);
      chk("seq_done_z",    bus.z_out, 16'd0);
      chk("seq_done_stop", 16'(bus.stage_stop), 16'd1);
      chk("seq_done_cin",  {14'd0, bus.x_cin, bus.y_cin}, 16'd0);
      tick();
      chk("seq_idle_done", 16'(bus.done), 16'd0);

      // angle = -atan(1): first step goes the other way and lands on zero.
      bus.angle = 16'(-6434);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      tick();
      chk("neg_xcin", 16'(bus.x_cin), 16'd0);
      chk("neg_ycin", 16'(bus.y_cin), 16'd1);
      tick();
      chk("neg_z1", bus.z_out, 16'd0);
      lat = 0;
      while (!bus.done && lat < 60) begin
         tick();
         lat++;
      end
      chk("neg_done_seen", 16'(bus.done), 16'd1);
      tick();

      // start held every cycle: one LOAD per 17 cycles, never back to back.
      loads     = 0;
      first_gap = 0;
      last_load = 0;
      prev_load = 1'b0;
      bus.angle = 16'd100;
      bus.start = 1'b1;
      for (int c = 1; c <= 51; c++) begin
         tick();
         if (bus.stage_load) begin
            if (loads == 1) first_gap = c - last_load;
            last_load = c;
            loads++;
            if (prev_load) chk("load_b2b", 16'd1, 16'd0);
         end
         prev_load = bus.stage_load;
      end
      bus.start = 1'b0;
      chk("load_count", 16'(loads), 16'd3);
      chk("load_gap",   16'(first_gap), 16'd17);
      lat = 0;
      while (bus.busy && lat < 60) begin
         tick();
         lat++;
      end
      chk("drain_idle", 16'(bus.busy), 16'd0);

      // Reset in the middle of an operation.
      bus.angle = 16'd4289;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      lat = 0;
      while (!(bus.stage_stop == 1'b0 && bus.iter_idx == 4'd7) && lat < 40) begin
         tick();
         lat++;
      end
      chk("mid_reached_i7", 16'(bus.iter_idx), 16'd7);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mid_busy", 16'(bus.busy), 16'd0);
      chk("mid_done", 16'(bus.done), 16'd0);
      chk("mid_stop", 16'(bus.stage_stop), 16'd1);
      saw_done = 1'b0;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (bus.done) saw_done = 1'b1;
      end
      chk("mid_no_done", 16'(saw_done), 16'd0);
      run_op(16'd4289, 16'd4975, 16'd0, lat);
      chk("mid_restart_lat", 16'(lat), 16'd16);
      chk("mid_restart_x",   sx, 16'd7098);
      chk("mid_restart_y",   sy, 16'd4095);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/cordic_rot_seq.md
# cordic_rot_seq

Iteration sequencer and angle datapath for the 16-bit rotation-mode CORDIC. It drives the x and y update stages, which are register-plus-adder slices with `load`, `stop` and `cin` inputs. It accepts a start request with a target angle and loads the stages. For ITER cycles it supplies their shifted cross-operands and add/subtract selects, tracks the residual angle z through an internal arctan ROM, and signals completion with a done pulse.

## Interface
Parameters:
- ITER, 14, number of micro-rotations; legal range 1..16.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  reset, synchronous, active-high.
- start  in  1  request; sampled only in IDLE.
- angle  in  16  target angle, two's complement Q3.13 radians (1 LSB = 2^-13 rad).
- x_in  in  16  current x-stage register value.
- y_in  in  16  current y-stage register value.
- stage_load  out  1  drives the stages' load/reset input; high for exactly the LOAD cycle.
- stage_stop  out  1  stage hold; low only in ITER.
- x_cin  out  1  x-stage select; 1 = subtract (x − y_opnd).
- y_cin  out  1  y-stage select; 1 = subtract (y − x_opnd).
- x_opnd  out  16  y_in >>> i, arithmetic shift; feeds the x stage.
- y_opnd  out  16  x_in >>> i, arithmetic shift; feeds the y stage.
- z_out  out  16  residual angle register.
- iter_idx  out  4  current iteration index i.
- busy  out  1  high in LOAD, ITER and DONE.
- done  out  1  one-cycle completion pulse.

## Operation
- FSM states: IDLE, LOAD, ITER, DONE.
  - IDLE→LOAD when start=1. On that edge z<=angle and i<=0.
  - LOAD→ITER unconditionally.
  - In ITER, i<=i+1 each edge. ITER→DONE on the edge where i==ITER−1.
  - DONE→IDLE unconditionally.
- start is ignored outside IDLE; no queuing.
- Direction: σ = ~z[15], so z≥0 gives σ=1.
  - In ITER, x_cin=σ and y_cin=~σ. This gives x−=y>>i and y+=x>>i for σ=1, and the reverse for σ=0.
  - Outside ITER, x_cin=y_cin=0.
- z update in ITER: z<=z−atan[i] if σ=1, else z<=z+atan[i].
  - Arithmetic is 16-bit modulo 2^16, no saturation. z holds in all other states.
- atan ROM, round(atan(2^-i)·8192), i=0..15:
  - 6434, 3798, 2007, 1019, 511, 256, 128, 64, 32, 16, 8, 4, 2, 1, 0, 0.
- Shifts are combinational from the registered i. For i=15, the operand is all sign bits.
- Convergence is guaranteed for |angle| ≤ 12868 (π/2). Outside that range the result is undefined but the sequencing is unchanged.
- Reset values: state=IDLE, i=0, z=0, stage_load=0, stage_stop=1, busy=0, done=0, x_cin=y_cin=0.
  - Reset during LOAD, ITER or DONE aborts the operation with no done pulse.
  - Reset overrides a simultaneous start.

## Timing
- All outputs except x_opnd and y_opnd are decoded from registered state, i and z only. They are glitch-free relative to clk and have no combinational path from start or angle.
- Let E0 be the edge that samples start. Then:
  - The LOAD cycle follows E0; the stages capture x0/y0 at the end of it.
  - ITER cycles follow, ITER of them; the stages update at each of their ending edges.
  - The DONE cycle comes next, with stage results and z_out final and stable.
- done is high in cycle ITER+2 after E0, which is cycle 16 at the default.
- Throughput: one operation per ITER+3 cycles. start may be asserted in the cycle after DONE.
- stage_stop=1 during LOAD and DONE, so the stage registers hold after the last iteration until the next LOAD.

## Test plan
- Reset: assert reset 2 cycles with start=1 → stage_stop=1, stage_load=0, busy=0, z_out=0, no LOAD entered.
- angle=0, ITER=14:
  - σ sequence 1,0,0,0,1,0,1,1,0,0,0,0,1,1.
  - z trace −6434, −2636, −629, 390, −121, 135, 7, −57, −25, −9, −1, 3, 1, 0.
  - done at cycle 16, z_out=0.
- angle=4289 (π/6), x0=4975 (K·8192), y0=0 with behavioural stages → done with x≈7094, y≈4096 (±4 LSB); |z_out| ≤ 2.
- angle=−6434:
  - i=0 gives x_cin=0, y_cin=1; z<=0 after the first edge.
  - Mirror check: angle=−4289 gives y≈−4096.
- start pulsed every cycle from IDLE → exactly one LOAD per ITER+3 cycles; starts during busy are dropped; stage_load is never high two cycles in a row.
- Reset asserted at i=7 → next cycle IDLE, busy=0, no done; a subsequent start completes normally.
